somador_par_impar_seq: RTL

- Parametrised sequential successor to the six-channel parity adder.
- Accepts one vector of N_CH unsigned W-bit operands per transaction over a valid/ready handshake.
- Accumulates the operands serially, one channel per clock, then presents the full sum and an odd/even flag on a valid/ready output.
- Sits between the operand-entry logic and the display/decision logic that consumes p_ou_i.

---
 rtl/somador_pkg.sv | 38 +++
 rtl/somador_sel_canal.sv | 47 ++++
 rtl/somador_par_impar_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/somador_pkg.sv
// -----------------------------------------------------------------------------
// somador_pkg
//
// Shared definitions for the sequential parity adder (somador_par_impar_seq)
// and its channel selector (somador_sel_canal).
//
// Contents:
//   estado_t    - controller state encoding (OCIOSO / ACUM / PRONTO)
//   N_CH_DEF    - default number of operand channels
//   W_DEF       - default operand width
//   IDX_W_DEF   - channel-index width for the default channel count
//   calc_sw     - sum width that holds N_CH*(2^W-1) without overflow
//   calc_idx_w  - channel-index width for an arbitrary channel count
// -----------------------------------------------------------------------------
package somador_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,  // idle, waiting for an operand vector
        ACUM   = 2'd1,  // accumulating one channel per clock
        PRONTO = 2'd2   // result held until the consumer takes it
    } estado_t;

    localparam int N_CH_DEF  = 6;
    localparam int W_DEF     = 4;
    localparam int IDX_W_DEF = $clog2(N_CH_DEF);

    // N_CH operands of W bits sum to at most N_CH*(2^W-1) < 2^(W+clog2(N_CH)).
    function automatic int calc_sw(input int n_ch, input int w);
        return w + $clog2(n_ch);
    endfunction

    // With N_CH >= 2 this is just $clog2(N_CH); the guard keeps the index
    // at least one bit wide should anyone instantiate a degenerate block.
    function automatic int calc_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage : somador_pkg

// File: rtl/somador_sel_canal.sv
// -----------------------------------------------------------------------------
// somador_sel_canal
//
// Combinational N_CH:1 multiplexer that presents operand[idx] to the
// accumulator. Channel i lives at operandos[i*W +: W].
//
// Optional feature (macro SOMADOR_MASK_EN): adds the mascara input; a channel
// whose mask bit is 0 is presented as zero, so it still occupies its cycle in
// the accumulation but contributes nothing.
//
// Ports:
//   operandos  in  N_CH*W  captured operand vector
//   mascara    in  N_CH    per-channel enable (only with SOMADOR_MASK_EN)
//   idx        in  IDX_W   channel currently being accumulated
//   operando   out W       selected (and possibly masked) operand
// -----------------------------------------------------------------------------
module somador_sel_canal
    import somador_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int W     = W_DEF,
    parameter int IDX_W = calc_idx_w(N_CH)
) (
    input  logic [N_CH*W-1:0] operandos,
`ifdef SOMADOR_MASK_EN
    input  logic [N_CH-1:0]   mascara,
`endif
    input  logic [IDX_W-1:0]  idx,
    output logic [W-1:0]      operando
);

    // The controller never drives idx past N_CH-1, so an out-of-range index
    // simply selects zero rather than needing a separate error path.
    always_comb begin
        operando = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == IDX_W'(i)) begin
`ifdef SOMADOR_MASK_EN
                operando = mascara[i] ? operandos[i*W +: W] : '0;
`else
                operando = operandos[i*W +: W];
`endif
            end
        end
    end

endmodule : somador_sel_canal

// File: rtl/somador_par_impar_seq.sv
// -----------------------------------------------------------------------------
// somador_par_impar_seq
//
// Sequential parity adder. Accepts one vector of N_CH unsigned W-bit operands
// over a valid/ready handshake, adds them serially (one channel per clock),
// then presents the full sum and its odd/even flag over a valid/ready output.
//
// Timing: a vector accepted at edge k produces out_valid=1 after edge k+N_CH.
// With out_ready held high one result is produced every N_CH+2 cycles.
// soma/p_ou_i only ever show complete sums and keep the last result after the
// output handshake until the next result loads.
//
// Optional feature (macro SOMADOR_MASK_EN): adds port ch_mask, captured with
// in_data; channels with mask bit 0 contribute zero without changing latency.
//
// Ports:
//   clk        in  1       system clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   in_valid   in  1       operand vector valid
//   in_ready   out 1       block can accept a vector (idle)
//   in_data    in  N_CH*W  packed operands, channel i at [i*W +: W]
//   ch_mask    in  N_CH    per-channel enable (only with SOMADOR_MASK_EN)
//   out_valid  out 1       result valid
//   out_ready  in  1       consumer accepts the result
//   soma       out SW      unsigned sum of all (enabled) channels
//   p_ou_i     out 1       parity of soma: 1 = odd (impar), 0 = even (par)
// -----------------------------------------------------------------------------
module somador_par_impar_seq
    import somador_pkg::*;
#(
    parameter  int N_CH = N_CH_DEF,
    parameter  int W    = W_DEF,
    localparam int SW   = calc_sw(N_CH, W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] in_data,
`ifdef SOMADOR_MASK_EN
    input  logic [N_CH-1:0]   ch_mask,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     soma,
    output logic              p_ou_i
);

    localparam int IDX_W = calc_idx_w(N_CH);
    localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(N_CH - 1);

    estado_t            estado_q;
    estado_t            estado_d;

    logic               aceita;        // input handshake this cycle
    logic               ultimo;        // last channel is being added now

    logic [N_CH*W-1:0]  opnd_p0;       // operand vector captured on accept
`ifdef SOMADOR_MASK_EN
    logic [N_CH-1:0]    mask_p0;
`endif
    logic [IDX_W-1:0]   idx_p0;        // channel being added this cycle
    logic [W-1:0]       operando;      // operand[idx], masked if enabled
    logic [SW-1:0]      acc_p1;        // running partial sum
    logic [SW-1:0]      soma_prox;     // partial sum including operand[idx]
    logic [SW-1:0]      soma_p2;       // last complete result

    // -------------------------------------------------------------------------
    // Controller: state register / next-state / outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO: if (in_valid)  estado_d = ACUM;
            ACUM:   if (ultimo)    estado_d = PRONTO;
            PRONTO: if (out_ready) estado_d = OCIOSO;
            default:               estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        in_ready  = (estado_q == OCIOSO);
        out_valid = (estado_q == PRONTO);
    end

    assign aceita = in_valid && in_ready;
    assign ultimo = (estado_q == ACUM) && (idx_p0 == IDX_ULTIMO);

    // -------------------------------------------------------------------------
    // Stage 0: operand capture and channel index
    // -------------------------------------------------------------------------
    // The vector is held locally so the source may change in_data as soon as
    // the handshake completes. idx returns to 0 after the last channel so it
    // never points beyond N_CH-1, even while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_p0 <= '0;
`ifdef SOMADOR_MASK_EN
            mask_p0 <= '0;
`endif
            idx_p0  <= '0;
        end else if (aceita) begin
            opnd_p0 <= in_data;
`ifdef SOMADOR_MASK_EN
            mask_p0 <= ch_mask;
`endif
            idx_p0  <= '0;
        end else if (estado_q == ACUM) begin
            idx_p0  <= ultimo ? '0 : idx_p0 + 1'b1;
        end
    end

    somador_sel_canal #(
        .N_CH  (N_CH),
        .W     (W),
        .IDX_W (IDX_W)
    ) u_sel_canal (
        .operandos (opnd_p0),
`ifdef SOMADOR_MASK_EN
        .mascara   (mask_p0),
`endif
        .idx       (idx_p0),
        .operando  (operando)
    );

    // -------------------------------------------------------------------------
    // Stage 1: serial accumulation
    // -------------------------------------------------------------------------
    // SW is wide enough for the full sum, so zero-extending each operand and
    // adding cannot wrap.
    assign soma_prox = acc_p1 + {{(SW-W){1'b0}}, operando};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p1 <= '0;
        end else if (aceita) begin
            acc_p1 <= '0;
        end else if (estado_q == ACUM) begin
            acc_p1 <= soma_prox;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: result register
    // -------------------------------------------------------------------------
    // Loaded only with the final sum, so consumers never see a partial value;
    // it is left untouched by the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            soma_p2 <= '0;
        end else if (ultimo) begin
            soma_p2 <= soma_prox;
        end
    end

    assign soma   = soma_p2;
    assign p_ou_i = soma_p2[0];

endmodule : somador_par_impar_seq
